// File: rtl/move_arb_mux.sv
// ---------------------------------------------------------------------------
// move_arb_mux
//
// Registered N-way move multiplexer with valid/ready handshakes. One of
// NUM_IN WIDTH-bit sources is chosen either by an explicit select code
// (mode = 0) or by round-robin arbitration (mode = 1). The chosen word is
// held in a one-entry output buffer so producers and consumer are decoupled.
//
// Parameters:
//   WIDTH   data width of every source and of the output
//   NUM_IN  number of source channels (2..16)
//   SEL_W   width of the select and source-index fields
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    packed sources, channel i at [i*WIDTH +: WIDTH]
//   in_valid   channel i offers a word
//   in_ready   channel i word accepted this cycle (at most one bit high)
//   mode       0 = explicit select, 1 = round-robin
//   sel        source index used in mode 0
//   out_data   buffered word
//   out_src    index of the channel that supplied out_data
//   out_valid  buffer holds a word
//   out_ready  consumer takes the word when out_valid & out_ready
// ---------------------------------------------------------------------------
module move_arb_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // One extra bit so that NUM_IN itself is representable (e.g. NUM_IN = 16).
    localparam logic [SEL_W:0]   NUM_IN_EXT = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_IN-1);

    logic [WIDTH-1:0] chan [NUM_IN];

    logic [WIDTH-1:0] out_data_reg,  out_data_next;
    logic [SEL_W-1:0] out_src_reg,   out_src_next;
    logic             out_valid_reg, out_valid_next;
    logic [SEL_W-1:0] ptr_reg,       ptr_next;

    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] rr_idx;
    logic             sel_in_range;
    logic             load_ok;
    logic             xfer;

    // Unpack the flat source bus into per-channel words.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
            assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign sel_in_range = ({1'b0, sel} < NUM_IN_EXT);

    // Grant selection. Round-robin walks from ptr+1 upward with wrap, so the
    // most recently served channel has lowest priority next time.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_idx      = ptr_reg;
        if (!mode) begin
            if (sel_in_range && in_valid[sel]) begin
                grant_valid = 1'b1;
                grant_idx   = sel;
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                rr_idx = (rr_idx == LAST_IDX) ? '0 : rr_idx + SEL_W'(1);
                if (!grant_valid && in_valid[rr_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = rr_idx;
                end
            end
        end
    end

    // The buffer may load when empty or when its word leaves this cycle.
    // Reset gates the handshake so no channel sees ready while held in reset.
    assign load_ok = !out_valid_reg || out_ready;
    assign xfer    = grant_valid && load_ok && !reset;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
            assign in_ready[gi] = xfer && (grant_idx == SEL_W'(gi));
        end
    endgenerate

    // Buffer next state. A drain without a new word only clears valid; data
    // and source index keep their last values.
    always_comb begin
        out_data_next  = out_data_reg;
        out_src_next   = out_src_reg;
        out_valid_next = out_valid_reg;
        ptr_next       = ptr_reg;
        if (xfer) begin
            out_data_next  = chan[grant_idx];
            out_src_next   = grant_idx;
            out_valid_next = 1'b1;
            if (mode) begin
                ptr_next = grant_idx;
            end
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // ptr resets to the last channel so channel 0 wins the first arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_reg  <= '0;
            out_src_reg   <= '0;
            out_valid_reg <= 1'b0;
            ptr_reg       <= LAST_IDX;
        end else begin
            out_data_reg  <= out_data_next;
            out_src_reg   <= out_src_next;
            out_valid_reg <= out_valid_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_move_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_move_arb_mux
//
// Table-driven bench for move_arb_mux (NUM_IN = 4) plus hand-written
// sequences for reset, a NUM_IN = 3 instance and an asynchronous reset
// pulse while stalled. Buffered words are tracked in a scoreboard queue:
// pushed when a grant is expected, popped when the consumer drains.
// ---------------------------------------------------------------------------
module tb_move_arb_mux;

    logic         clk = 1'b0;
    logic         reset;

    // NUM_IN = 4 instance
    logic [31:0]  chan [4];
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         out_valid;
    logic         out_ready;

    // NUM_IN = 3 instance
    logic [31:0]  b_chan [3];
    logic [95:0]  b_in_data;
    logic [2:0]   b_in_valid;
    logic [2:0]   b_in_ready;
    logic         b_mode;
    logic [1:0]   b_sel;
    logic [31:0]  b_out_data;
    logic [1:0]   b_out_src;
    logic         b_out_valid;
    logic         b_out_ready;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic       m;
        logic [1:0] s;
        logic [3:0] v;
        logic       r;
        logic [3:0] er;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign in_data   = {chan[3], chan[2], chan[1], chan[0]};
    assign b_in_data = {b_chan[2], b_chan[1], b_chan[0]};

    move_arb_mux #(.WIDTH(32), .NUM_IN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    move_arb_mux #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .mode      (b_mode),
        .sel       (b_sel),
        .out_data  (b_out_data),
        .out_src   (b_out_src),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // Drive one cycle on the 4-channel instance, check at the falling edge,
    // then update the scoreboard for what the next rising edge does.
    task automatic apply(input logic m, input logic [1:0] s, input logic [3:0] v,
                         input logic r, input logic [3:0] er, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        mode = m; sel = s; in_valid = v; out_ready = r;
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(in_ready), 64'(er));
        chk({tag, " out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, " out_data"}, 64'(out_data), 64'(q[0].d));
            chk({tag, " out_src"}, 64'(out_src), 64'(q[0].s));
            if (r) begin
                $display("%s: drained src=%0d data=%h", tag, out_src, out_data);
                void'(q.pop_front());
            end
        end
        if (er != 4'b0000) begin
            e.d = '0; e.s = '0;
            for (int i = 0; i < 4; i++) begin
                if (er[i]) begin
                    e.d = chan[i];
                    e.s = 2'(i);
                end
            end
            q.push_back(e);
        end
    endtask

    initial begin
        logic [2:0] b_exp [4];
        logic [1:0] b_prev;

        chan[0] = 32'h12345678; chan[1] = 32'hA1A1A1A1;
        chan[2] = 32'hDEADBEEF; chan[3] = 32'hA3A3A3A3;
        b_chan[0] = 32'hB0B0B0B0; b_chan[1] = 32'hB1B1B1B1; b_chan[2] = 32'hB2B2B2B2;

        // Reset held with every channel offering and the consumer ready.
        reset = 1'b1;
        mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
        b_mode = 1'b0; b_sel = 2'd0; b_in_valid = 3'b111; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst out_src", 64'(out_src), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst b_in_ready", 64'(b_in_ready), 64'd0);
        chk("rst b_out_valid", 64'(b_out_valid), 64'd0);
        in_valid = 4'b0000;
        b_in_valid = 3'b000;
        reset = 1'b0;

        // {mode, sel, in_valid, out_ready, expected in_ready}
        // Round-robin, all valid: 0,1,2,3,0,1,2,3
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000});
        // Round-robin, channels 1 and 3 only: 1,3,1,3
        tbl.push_back('{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010});
        tbl.push_back('{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000});
        tbl.push_back('{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010});
        tbl.push_back('{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000});
        // Explicit select of channel 2, then it goes idle
        tbl.push_back('{1'b0, 2'd2, 4'b0101, 1'b1, 4'b0100});
        tbl.push_back('{1'b0, 2'd2, 4'b0001, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000});
        // Mode 0 left ptr at 3, so round-robin resumes at channel 0
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001});
        // sel changes while a word is buffered
        tbl.push_back('{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000});
        // Load 12345678, then stall three cycles
        tbl.push_back('{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000});
        // Release: replace in the same cycle; ptr still 0 so channel 1 wins
        tbl.push_back('{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000});

        foreach (tbl[i])
            apply(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].r, tbl[i].er, $sformatf("vec%0d", i));

        // NUM_IN = 3: explicit select of 0, then out-of-range select 3
        @(posedge clk); #1;
        b_mode = 1'b0; b_sel = 2'd0; b_in_valid = 3'b111; b_out_ready = 1'b1;
        @(negedge clk);
        chk("n3 sel0 in_ready", 64'(b_in_ready), 64'b001);
        @(posedge clk); #1;
        b_sel = 2'd3;
        @(negedge clk);
        chk("n3 sel3 in_ready", 64'(b_in_ready), 64'b000);
        chk("n3 sel3 out_valid", 64'(b_out_valid), 64'd1);
        chk("n3 sel3 out_data", 64'(b_out_data), 64'(b_chan[0]));
        $display("n3: drained src=%0d data=%h", b_out_src, b_out_data);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n3 sel3 drained", 64'(b_out_valid), 64'd0);
        chk("n3 sel3 still idle", 64'(b_in_ready), 64'b000);

        // NUM_IN = 3 round-robin wraps 0,1,2,0
        b_exp[0] = 3'b001; b_exp[1] = 3'b010; b_exp[2] = 3'b100; b_exp[3] = 3'b001;
        b_prev = 2'd0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            b_mode = 1'b1;
            @(negedge clk);
            chk($sformatf("n3 rr%0d in_ready", k), 64'(b_in_ready), 64'(b_exp[k]));
            if (k > 0) begin
                chk($sformatf("n3 rr%0d out_src", k), 64'(b_out_src), 64'(b_prev));
                $display("n3: drained src=%0d data=%h", b_out_src, b_out_data);
            end
            for (int i = 0; i < 3; i++)
                if (b_exp[k][i]) b_prev = 2'(i);
        end
        b_in_valid = 3'b000;

        // Asynchronous reset pulse while stalled with a full buffer
        apply(1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, "ar_load");
        apply(1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, "ar_stall");
        #1 reset = 1'b1;
        #1;
        chk("ar out_valid", 64'(out_valid), 64'd0);
        chk("ar out_data", 64'(out_data), 64'd0);
        chk("ar out_src", 64'(out_src), 64'd0);
        chk("ar in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        q.delete();
        // ptr was reset too, so round-robin restarts at channel 0
        apply(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "post_rst");
        apply(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, "post_drain");
        apply(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, "post_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
